layer_compositor: RTL
=====================

// Module: layer_compositor
// PURPOSE
// - Stage directly downstream of the background layer and the foreground layers (sprites/UI).
// - Merges the opaque background pixel with NUM_FG colour-keyed foreground layers by fixed priority.
// - Realigns hsync/vsync/active-video with the memory read latency of the layers.
// - Drives registered 4:4:4 RGB plus sync to the VGA pins, blanking outside active video.
// PARAMETERS
// - NUM_FG         3       number of foreground layers; fg index NUM_FG-1 is topmost
// - LAYER_LATENCY  1       pix_en cycles from h_cnt/v_cnt to layer pixel arrival (BRAM read), >=1
// - TRANSPARENT    12'hF0F colour key; a foreground pixel equal to it is transparent
// PORTS
// - clk        in   1          system clock
// - rst        in   1          synchronous reset, active-high
// - pix_en     in   1          pixel-clock enable (1-in-4 at 100 MHz); pipeline advances only when high
// - hsync_in   in   1          horizontal sync, aligned with h_cnt (active-low)
// - vsync_in   in   1          vertical sync, aligned with v_cnt (active-low)
// - valid_in   in   1          active-video flag, aligned with h_cnt/v_cnt
// - bg_pixel   in   12         background RGB {r,g,b}, arrives LAYER_LATENCY pix_en cycles after valid_in
// - fg_pixel   in   12*NUM_FG  foreground RGBs, layer i at [12*i+:12], same alignment as bg_pixel
// - fade_level in   4          global brightness (used only with LAYER_FADE_EN)
// - vga_r/g/b  out  4 each     registered colour outputs
// - hsync      out  1          delayed hsync
// - vsync      out  1          delayed vsync
// - frame_start out 1          one-clk pulse on the enabled edge where delayed vsync falls
// BEHAVIOUR
// - Reset: vga_r/g/b=0, hsync=vsync=1, frame_start=0; all delay-line taps cleared to sync=1, valid=0.
// - rst has priority over pix_en; reset mid-frame flushes the pipeline, no stale pixel survives.
// - pix_en=0: every register holds; frame_start forced 0 on that cycle.
// - Delay line: hsync_in/vsync_in/valid_in shifted LAYER_LATENCY pix_en stages to meet layer data.
// - Select (combinational on aligned data): highest i with fg[i]!=TRANSPARENT wins; else bg_pixel.
// - Background is always opaque; bg_pixel equal to TRANSPARENT is drawn as-is.
// - Output register: if aligned valid=1, rgb=selected pixel; else rgb=0. Sync registered alongside.
// - Total latency input -> pins: LAYER_LATENCY+1 enabled cycles, identical for rgb, hsync, vsync.
// - frame_start: vsync output register goes 1->0 on an enabled edge -> pulse high exactly that clk.
// - No arithmetic without the option below; pure selection, widths unchanged.
// CONFIGURATION
// - LAYER_FADE_EN defined: extra pipeline stage after select; latency LAYER_LATENCY+2 for all outputs.
//   - Channel out = (c * (fade_q+1)) >> 4, c 4-bit, product 9-bit; fade_q=15 -> unchanged, 0 -> c>>4=0.
//   - fade_q captured from fade_level only at a frame_start event; reset value 4'hF.
//   - Mid-frame fade_level changes take effect from the next frame only (no tearing).
// - LAYER_FADE_EN undefined: fade_level ignored, no extra stage, latency LAYER_LATENCY+1.
// TESTING
// - Reset: rst=1 two clks, pix_en=1 -> rgb=0, hsync=1, vsync=1, frame_start=0.
// - Latency (LAYER_LATENCY=1, pix_en=1): valid_in=1 at t, bg=12'h122 at t+1, fg all F0F -> rgb=1/2/2 at t+2.
// - Priority: fg0=F0F, fg1=ABC, bg=111 -> ABC; fg1=F0F, fg0=0F0 -> 0F0; fg2=F00 over fg1=ABC -> F00; all keyed -> 111.
// - Blanking/sync: valid_in=0, bg=FFF -> rgb=000; hsync_in pulse low 96 enabled cycles -> hsync low 96 cycles, 2 later.
// - Enable: pix_en high 1 of 4 clks -> outputs change only on enabled edges; latency counted in enabled edges.
// - LAYER_FADE_EN: fade_level=7 set mid-frame, bg=FFF -> rgb stays F until next frame_start, then 7/7/7.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: merges an opaque background pixel with NUM_FG colour-keyed
// foreground layers by fixed priority, realigns sync/active-video with the layer
// read latency and drives registered 4:4:4 RGB plus sync to the VGA pins.
// Optional feature macro: LAYER_FADE_EN (adds a global fade stage, +1 latency).
module layer_compositor #(
   parameter int          NUM_FG        = 3,
   parameter int          LAYER_LATENCY = 1,
   parameter logic [11:0] TRANSPARENT   = 12'hF0F
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_en,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  valid_in,
   input  logic [11:0]           bg_pixel,
   input  logic [12*NUM_FG-1:0]  fg_pixel,
   input  logic [3:0]            fade_level,
   output logic [3:0]            vga_r,
   output logic [3:0]            vga_g,
   output logic [3:0]            vga_b,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  frame_start
);

   // control delay line, tap LAYER_LATENCY-1 lines up with layer pixel data
   logic [LAYER_LATENCY-1:0] r_hs_dly;
   logic [LAYER_LATENCY-1:0] r_vs_dly;
   logic [LAYER_LATENCY-1:0] r_vl_dly;

   logic        w_hs_al, w_vs_al, w_vl_al;
   logic [11:0] w_sel;
   logic [11:0] w_rgb_next;
   logic        w_hs_next, w_vs_next;

   logic [11:0] r_rgb;
   logic        r_hs, r_vs, r_fs;

   // shift sync/valid by LAYER_LATENCY enabled cycles; reset fills with idle values
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs_dly <= '1;
         r_vs_dly <= '1;
         r_vl_dly <= '0;
      end else if (pix_en) begin
         r_hs_dly[0] <= hsync_in;
         r_vs_dly[0] <= vsync_in;
         r_vl_dly[0] <= valid_in;
         for (int k = 1; k < LAYER_LATENCY; k++) begin
            r_hs_dly[k] <= r_hs_dly[k-1];
            r_vs_dly[k] <= r_vs_dly[k-1];
            r_vl_dly[k] <= r_vl_dly[k-1];
         end
      end
   end

   assign w_hs_al = r_hs_dly[LAYER_LATENCY-1];
   assign w_vs_al = r_vs_dly[LAYER_LATENCY-1];
   assign w_vl_al = r_vl_dly[LAYER_LATENCY-1];

   // priority select: later (higher index) opaque layers overwrite earlier ones
   always_comb begin
      w_sel = bg_pixel;
      for (int i = 0; i < NUM_FG; i++) begin
         if (fg_pixel[12*i +: 12] != TRANSPARENT)
            w_sel = fg_pixel[12*i +: 12];
      end
   end

`ifdef LAYER_FADE_EN
   logic [11:0] r_s_rgb;
   logic        r_s_hs, r_s_vs;
   logic [3:0]  r_fade_q;

   // scale one 4-bit channel by (fade+1)/16; fade=15 leaves it unchanged
   function automatic logic [3:0] fade_ch(input logic [3:0] c, input logic [3:0] f);
      logic [8:0] p;
      p = {5'd0, c} * ({5'd0, f} + 9'd1);
      return p[7:4];
   endfunction

   // select stage; fade level latched only on the frame_start edge so a frame never tears
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_rgb  <= 12'h000;
         r_s_hs   <= 1'b1;
         r_s_vs   <= 1'b1;
         r_fade_q <= 4'hF;
      end else if (pix_en) begin
         r_s_rgb <= w_vl_al ? w_sel : 12'h000;
         r_s_hs  <= w_hs_al;
         r_s_vs  <= w_vs_al;
         if (r_vs && !w_vs_next)
            r_fade_q <= fade_level;
      end
   end

   assign w_rgb_next = {fade_ch(r_s_rgb[11:8], r_fade_q),
                        fade_ch(r_s_rgb[7:4],  r_fade_q),
                        fade_ch(r_s_rgb[3:0],  r_fade_q)};
   assign w_hs_next  = r_s_hs;
   assign w_vs_next  = r_s_vs;
`else
   logic w_unused_fade;
   assign w_unused_fade = ^fade_level;

   assign w_rgb_next = w_vl_al ? w_sel : 12'h000;
   assign w_hs_next  = w_hs_al;
   assign w_vs_next  = w_vs_al;
`endif

   // pin register; frame_start pulses on the enabled edge where vsync falls
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rgb <= 12'h000;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
         r_fs  <= 1'b0;
      end else begin
         r_fs <= pix_en && r_vs && !w_vs_next;
         if (pix_en) begin
            r_rgb <= w_rgb_next;
            r_hs  <= w_hs_next;
            r_vs  <= w_vs_next;
         end
      end
   end

   assign vga_r       = r_rgb[11:8];
   assign vga_g       = r_rgb[7:4];
   assign vga_b       = r_rgb[3:0];
   assign hsync       = r_hs;
   assign vsync       = r_vs;
   assign frame_start = r_fs;

endmodule
